// File: rtl/pc_loop_if.sv
// Bus between a fetch-side observer and pc_loop_detector: pc samples and clear in, loop and stall flags out.
interface pc_loop_if #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned MAX_PERIOD = 4
);
  localparam int unsigned PW = $clog2(MAX_PERIOD + 1);

  logic                sample_valid;
  logic [PC_WIDTH-1:0] pc;
  logic                clear;
  logic                hang;
  logic [PW-1:0]       hang_period;
  logic [PC_WIDTH-1:0] hang_pc;
  logic                stall;

  modport master (
    output sample_valid, pc, clear,
    input  hang, hang_period, hang_pc, stall
  );

  modport slave (
    input  sample_valid, pc, clear,
    output hang, hang_period, hang_pc, stall
  );
endinterface

// File: rtl/pc_loop_detector.sv
// Detects a core stuck in a short pc loop (period 1..MAX_PERIOD repeated REPEATS times).
// Optional idle watchdog on the stall output is compiled in with `define PC_LOOP_WATCHDOG_EN.
module pc_loop_detector #(
  parameter int unsigned PC_WIDTH        = 32,
  parameter int unsigned MAX_PERIOD      = 4,
  parameter int unsigned REPEATS         = 10,
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input  logic      clk,
  input  logic      rst,
  pc_loop_if.slave  bus
);

  localparam int unsigned PW      = $clog2(MAX_PERIOD + 1);
  localparam int unsigned CNT_MAX = (REPEATS - 1) * MAX_PERIOD;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  logic [PC_WIDTH-1:0]   hist [MAX_PERIOD];
  logic [MAX_PERIOD-1:0] hist_vld;
  logic [CW-1:0]         run_cnt   [MAX_PERIOD];
  logic [CW-1:0]         run_nxt_c [MAX_PERIOD];
  logic                  hang_q;
  logic [PW-1:0]         period_q;
  logic [PC_WIDTH-1:0]   hang_pc_q;
  logic                  stall_q;
  logic                  accept_c;
  logic                  trig_c;
  logic [PW-1:0]         trig_period_c;

  assign accept_c = bus.sample_valid & ~bus.clear & ~hang_q;

  // Per-period run counters; scanning high to low lets the smallest triggering period win.
  always_comb begin
    trig_c        = 1'b0;
    trig_period_c = '0;
    for (int p = int'(MAX_PERIOD) - 1; p >= 0; p--) begin
      run_nxt_c[p] = '0;
      if (hist_vld[p] && (bus.pc == hist[p])) begin
        run_nxt_c[p] = (run_cnt[p] == CW'(CNT_MAX)) ? run_cnt[p] : run_cnt[p] + CW'(1);
        if (run_nxt_c[p] == CW'((REPEATS - 1) * unsigned'(p + 1))) begin
          trig_c        = 1'b1;
          trig_period_c = PW'(p + 1);
        end
      end
    end
  end

  // History data needs no reset: entries are qualified by hist_vld.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      hist[0] <= bus.pc;
      for (int i = 1; i < int'(MAX_PERIOD); i++) begin
        hist[i] <= hist[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      hist_vld  <= '0;
      hang_q    <= 1'b0;
      period_q  <= '0;
      hang_pc_q <= '0;
      for (int p = 0; p < int'(MAX_PERIOD); p++) begin
        run_cnt[p] <= '0;
      end
    end else if (accept_c) begin
      hist_vld[0] <= 1'b1;
      for (int i = 1; i < int'(MAX_PERIOD); i++) begin
        hist_vld[i] <= hist_vld[i-1];
      end
      for (int p = 0; p < int'(MAX_PERIOD); p++) begin
        run_cnt[p] <= run_nxt_c[p];
      end
      if (trig_c) begin
        hang_q    <= 1'b1;
        period_q  <= trig_period_c;
        hang_pc_q <= bus.pc;
      end
    end
  end

`ifdef PC_LOOP_WATCHDOG_EN
  localparam int unsigned WW = $clog2(WATCHDOG_CYCLES + 1);

  logic [WW-1:0] idle_cnt;
  logic [WW-1:0] idle_nxt_c;

  // Idle counter saturates at the limit; runs regardless of hang.
  always_comb begin
    idle_nxt_c = idle_cnt;
    if (bus.sample_valid) begin
      idle_nxt_c = '0;
    end else if (idle_cnt != WW'(WATCHDOG_CYCLES)) begin
      idle_nxt_c = idle_cnt + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      idle_cnt <= '0;
      stall_q  <= 1'b0;
    end else begin
      idle_cnt <= idle_nxt_c;
      if (idle_nxt_c == WW'(WATCHDOG_CYCLES)) begin
        stall_q <= 1'b1;
      end
    end
  end
`else
  assign stall_q = 1'b0;
`endif

  assign bus.hang        = hang_q;
  assign bus.hang_period = period_q;
  assign bus.hang_pc     = hang_pc_q;
  assign bus.stall       = stall_q;

endmodule

// File: tb/tb_pc_loop_detector.sv
// Scoreboard bench for pc_loop_detector: driver queues hand-computed expectations, monitor checks after each edge.
module tb_pc_loop_detector;

  localparam int unsigned PC_WIDTH   = 32;
  localparam int unsigned MAX_PERIOD = 4;
`ifdef PC_LOOP_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef struct {
    logic        hang;
    logic [2:0]  period;
    logic [31:0] hpc;
    logic        stall;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pc_loop_if #(.PC_WIDTH(PC_WIDTH), .MAX_PERIOD(MAX_PERIOD)) bus ();

  pc_loop_detector #(
    .PC_WIDTH(PC_WIDTH), .MAX_PERIOD(MAX_PERIOD), .REPEATS(10), .WATCHDOG_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs; when chk is set queue the outputs expected after the coming edge.
  task automatic step(input bit sv, input logic [31:0] pcv, input bit clr, input bit r,
                      input bit chk, input bit eh, input int ep, input logic [31:0] epc,
                      input bit es, input string nm);
    exp_t e;
    @(negedge clk);
    rst              = r;
    bus.sample_valid = sv;
    bus.pc           = pcv;
    bus.clear        = clr;
    if (chk) begin
      e.hang   = eh;
      e.period = 3'(ep);
      e.hpc    = epc;
      e.stall  = es;
      e.name   = nm;
      sb.push_back(e);
    end
  endtask

  task automatic do_clear();
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, "clear");
  endtask

  // n identical samples; only the last may raise hang (period 1)
  task automatic run_same(input int n, input logic [31:0] v, input bit last_hang, input string nm);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1 && last_hang)
        step(1'b1, v, 1'b0, 1'b0, 1'b1, 1'b1, 1, v, 1'b0, nm);
      else
        step(1'b1, v, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, nm);
    end
  endtask

  // Monitor: outputs settle after each edge, compare against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if (bus.hang !== e.hang || bus.hang_period !== e.period ||
            bus.hang_pc !== e.hpc || bus.stall !== e.stall) begin
          n_fail++;
          $display("FAIL %s: got hang=%0b period=%0d pc=%h stall=%0b, want hang=%0b period=%0d pc=%h stall=%0b",
                   e.name, bus.hang, bus.hang_period, bus.hang_pc, bus.stall,
                   e.hang, e.period, e.hpc, e.stall);
        end
      end
    end
  end

  initial begin
    rst              = 1'b1;
    bus.sample_valid = 1'b0;
    bus.pc           = '0;
    bus.clear        = 1'b0;

    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0, "");
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 32'h0, 1'b0, "reset_state");

    // period 1: ten 0x10 samples
    run_same(10, 32'h10, 1'b1, "p1_0x10");
    step(1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 1'b1, 1, 32'h10, 1'b0, "p1_frozen");
    do_clear();

    // period 2: 0x20,0x24 ten times
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, "p2_a");
      if (i == 9)
        step(1'b1, 32'h24, 1'b0, 1'b0, 1'b1, 1'b1, 2, 32'h24, 1'b0, "p2_hit");
      else
        step(1'b1, 32'h24, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, "p2_b");
    end
    do_clear();

    // period 3: 1,2,3 ten times
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, "p3_a");
      step(1'b1, 32'h2, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, "p3_b");
      if (i == 9)
        step(1'b1, 32'h3, 1'b0, 1'b0, 1'b1, 1'b1, 3, 32'h3, 1'b0, "p3_hit");
      else
        step(1'b1, 32'h3, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, "p3_c");
    end
    do_clear();

    // straight-line code never hangs; after clear the last pc must not count as history
    for (int i = 0; i < 200; i++)
      step(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, "linear");
    do_clear();
    run_same(10, 32'h31C, 1'b1, "post_clear_hist");
    do_clear();

    // reset mid-run discards progress
    run_same(9, 32'h40, 1'b0, "pre_rst");
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 32'h0, 1'b0, "mid_rst");
    run_same(10, 32'h40, 1'b1, "post_rst");

    // clear with a simultaneous sample: sample is discarded
    step(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, "clear_vs_sample");
    run_same(10, 32'h40, 1'b1, "retrigger");
    do_clear();

    // watchdog: 15 idle cycles then a sample -> no stall; 16 idle -> stall when enabled
    for (int i = 0; i < 15; i++)
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, "idle15");
    step(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, "idle15_sample");
    for (int i = 0; i < 15; i++)
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, "idle16_pre");
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0, WD_EN, "idle16_stall");
    step(1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0, WD_EN, "stall_sticky");
    do_clear();

    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0, "");
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_loop_detector.md
PC_LOOP_DETECTOR -- requirements
Module: pc_loop_detector

Interface
REQ-001 Parameter PC_WIDTH, default 32: width of the sampled program counter.
REQ-002 Parameter MAX_PERIOD, default 4: longest loop period detected, in samples; legal range 1..16.
REQ-003 Parameter REPEATS, default 10: number of identical consecutive loop iterations that constitutes a hang; legal range 2..255.
REQ-004 Parameter WATCHDOG_CYCLES, default 1024: idle-cycle limit, used only when the watchdog is compiled in.
REQ-005 Reset is synchronous and active-high, with a single clock: clk in, rst in, and all state updates on the posedge of clk.
REQ-006 clk  input  1  system clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 sample_valid  input  1  the core is in the fetch state this cycle, so pc is sampled.
REQ-009 pc  input  PC_WIDTH  fetch address, qualified by sample_valid.
REQ-010 clear  input  1  synchronous clear of history, counters and flags.
REQ-011 hang  output  1  sticky: a loop of some period 1..MAX_PERIOD has been detected.
REQ-012 hang_period  output  $clog2(MAX_PERIOD+1)  period of the detected loop; 0 when hang=0.
REQ-013 hang_pc  output  PC_WIDTH  pc value of the sample that triggered detection.
REQ-014 stall  output  1  sticky: watchdog expired, meaning no sample arrived for WATCHDOG_CYCLES cycles.

Function
REQ-015 History: shift register of the last MAX_PERIOD accepted samples, hist[0] newest, with per-entry valid bits; an accepted sample shifts in at the clock edge.
REQ-016 A sample is accepted when sample_valid=1, clear=0, rst=0 and hang=0.
REQ-017 For each p in 1..MAX_PERIOD, a match_p occurs when the accepted pc equals hist[p-1] and hist[p-1] is valid.
REQ-018 Each p has a run counter: it increments (saturating) on an accepted sample with match_p and resets to 0 on an accepted sample without match_p.
REQ-019 Run counter width is $clog2((REPEATS-1)*MAX_PERIOD+1); it saturates and never wraps.
REQ-020 Detection for period p occurs when the counter's next value equals (REPEATS-1)*p, i.e. the same p-sample pattern has occurred REPEATS times.
REQ-021 hang, hang_period and hang_pc register on the same edge that accepts the triggering sample, giving 1-cycle latency from that sample.
REQ-022 When several periods trigger on the same sample, the smallest p wins.
REQ-023 While hang=1, all samples are ignored and history and counters are frozen.
REQ-024 clear=1 empties history, zeroes counters and deasserts hang/stall on the next edge; clear wins over a simultaneous sample, which is discarded.
REQ-025 Case: a period-1 loop also satisfies period 2..MAX_PERIOD counters; REQ-022 resolves this as period 1.

Reset
REQ-026 On rst=1 at a clock edge, all of the following are cleared: history valid bits, run counters, hang=0, hang_period=0, hang_pc=0, stall=0, and the watchdog counter.
REQ-027 Reset asserted mid-run (during partial history or partial count) discards all progress, and detection restarts from empty history.

Configuration
REQ-028 Macro PC_LOOP_WATCHDOG_EN defined: the idle counter increments each cycle with sample_valid=0 and resets to 0 on any cycle with sample_valid=1; stall sets when the count reaches WATCHDOG_CYCLES and stays set until clear or rst.
REQ-029 Macro PC_LOOP_WATCHDOG_EN undefined: there is no idle counter, stall is tied to 0, and the port list is unchanged.
REQ-030 stall is independent of hang: both may be set, and hang freezing does not stop the watchdog.

Verification
REQ-031 Reset, then pc=0x10 accepted 10 consecutive times -> hang=1 one cycle after the 10th sample, with hang_period=1 and hang_pc=0x10; never set after the 9th.
REQ-032 Sequence 0x20,0x24 repeated 10 times (20 samples) -> hang=1 after sample 20 with hang_period=2 and hang_pc=0x24; hang=0 after sample 19.
REQ-033 Sequence 0x0,0x4,0x8,... incrementing by 4 for 200 samples -> hang stays 0; then clear -> outputs 0 and history empty.
REQ-034 pc=0x40 for 9 samples, rst for one cycle, then 0x40 for 9 more -> hang stays 0; a 10th post-reset sample -> hang=1.
REQ-035 After a hang, clear and sample_valid in the same cycle -> hang=0 and the sample is discarded; the next 10 identical samples are needed to re-trigger.
REQ-036 With PC_LOOP_WATCHDOG_EN and WATCHDOG_CYCLES=16, sample_valid held 0 for 16 cycles -> stall=1; held 0 for 15 cycles then 1 -> stall stays 0; without the macro -> stall=0 always.
